alu_op_issuer: RTL and testbench

Command-side initiator for the generated combinational ALUs. Accepts ALU operation requests on a valid/ready command channel, registers and drives the ALU opcode/operand/shift bus, waits a programmable settle time, then captures the ALU result and flags into a valid/ready response channel. Sits between the test/sequencer fabric and any generated ALU instance, giving that ALU a clocked, back-pressured front end.

---
 rtl/alu_op_issuer.sv | 134 +++++++++++++
 tb/tb_alu_op_issuer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - clocked, back-pressured command/response front end for a combinational ALU
// Optional sticky carry/overflow flags: define ALU_ISSUE_STICKY_EN.
module alu_op_issuer #(
  parameter int W       = 16,
  parameter int SHW     = 5,
  parameter int SETTLE  = 1,
  parameter int TAGW    = 4,
  parameter int NUM_OPS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_opcode,
  input  logic [W-1:0]    cmd_a,
  input  logic [W-1:0]    cmd_b,
  input  logic [SHW-1:0]  cmd_shift,
  input  logic [TAGW-1:0] cmd_tag,
  output logic [3:0]      alu_opcode,
  output logic [W-1:0]    alu_in1,
  output logic [W-1:0]    alu_in2,
  output logic [SHW-1:0]  alu_shift,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_carry,
  input  logic            alu_zero,
  input  logic            alu_ovf,
  input  logic            alu_sign,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_result,
  output logic [3:0]      rsp_flags,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_err,
  output logic [15:0]     op_count
`ifdef ALU_ISSUE_STICKY_EN
  ,
  input  logic            sticky_clr,
  output logic            sticky_carry,
  output logic            sticky_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       opcode_legal;

  assign opcode_legal = ({28'd0, cmd_opcode} < $unsigned(NUM_OPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cmd_ready    <= 1'b1;
      alu_opcode   <= 4'd0;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_shift    <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= 4'd0;
      rsp_tag      <= '0;
      rsp_err      <= 1'b0;
      op_count     <= 16'd0;
`ifdef ALU_ISSUE_STICKY_EN
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
`endif
    end else begin
`ifdef ALU_ISSUE_STICKY_EN
      if (sticky_clr) begin
        sticky_carry <= 1'b0;
        sticky_ovf   <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            rsp_tag   <= cmd_tag;
            cmd_ready <= 1'b0;
            if (opcode_legal) begin
              alu_opcode <= cmd_opcode;
              alu_in1    <= cmd_a;
              alu_in2    <= cmd_b;
              alu_shift  <= cmd_shift;
              cnt        <= CNT_INIT;
              state      <= DRIVE;
            end else begin
              // Rejected ops never touch the ALU bus; answer immediately.
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= 4'd0;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_carry, alu_ovf, alu_sign, alu_zero};
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
`ifdef ALU_ISSUE_STICKY_EN
            // A captured flag overrides a coincident clear.
            sticky_carry <= alu_carry | (sticky_carry & ~sticky_clr);
            sticky_ovf   <= alu_ovf   | (sticky_ovf   & ~sticky_clr);
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - directed self-checking bench for alu_op_issuer (SETTLE=1 and SETTLE=3 instances)
module tb_alu_op_issuer;

  localparam int W = 16;
  localparam int SHW = 5;
  localparam int TAGW = 4;

  logic clk;
  logic rst_n;

  logic            cmd_valid  [2];
  logic            cmd_ready  [2];
  logic [3:0]      cmd_opcode [2];
  logic [W-1:0]    cmd_a      [2];
  logic [W-1:0]    cmd_b      [2];
  logic [SHW-1:0]  cmd_shift  [2];
  logic [TAGW-1:0] cmd_tag    [2];
  logic [3:0]      alu_opcode [2];
  logic [W-1:0]    alu_in1    [2];
  logic [W-1:0]    alu_in2    [2];
  logic [SHW-1:0]  alu_shift  [2];
  logic [W-1:0]    alu_result [2];
  logic            alu_carry  [2];
  logic            alu_zero   [2];
  logic            alu_ovf    [2];
  logic            alu_sign   [2];
  logic            rsp_valid  [2];
  logic            rsp_ready  [2];
  logic [W-1:0]    rsp_result [2];
  logic [3:0]      rsp_flags  [2];
  logic [TAGW-1:0] rsp_tag    [2];
  logic            rsp_err    [2];
  logic [15:0]     op_count   [2];
`ifdef ALU_ISSUE_STICKY_EN
  logic            sticky_clr   [2];
  logic            sticky_carry [2];
  logic            sticky_ovf   [2];
`endif

  int checks = 0;
  int errors = 0;

  // Reference ALU: 0=ADD, 5=SLL, 7=OR, anything else yields 0. Returns {carry, ovf, result}.
  function automatic logic [W+1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [SHW-1:0] sh);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd5: r = a << sh;
      4'd7: r = a | b;
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign {alu_carry[g], alu_ovf[g], alu_result[g]} = alu_fn(alu_opcode[g], alu_in1[g], alu_in2[g], alu_shift[g]);
    assign alu_zero[g] = (alu_result[g] == '0);
    assign alu_sign[g] = alu_result[g][W-1];
  end

  alu_op_issuer #(.W(W), .SHW(SHW), .SETTLE(1), .TAGW(TAGW), .NUM_OPS(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_opcode(cmd_opcode[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_shift(cmd_shift[0]), .cmd_tag(cmd_tag[0]),
    .alu_opcode(alu_opcode[0]), .alu_in1(alu_in1[0]), .alu_in2(alu_in2[0]), .alu_shift(alu_shift[0]),
    .alu_result(alu_result[0]), .alu_carry(alu_carry[0]), .alu_zero(alu_zero[0]),
    .alu_ovf(alu_ovf[0]), .alu_sign(alu_sign[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_flags(rsp_flags[0]), .rsp_tag(rsp_tag[0]), .rsp_err(rsp_err[0]), .op_count(op_count[0])
`ifdef ALU_ISSUE_STICKY_EN
    , .sticky_clr(sticky_clr[0]), .sticky_carry(sticky_carry[0]), .sticky_ovf(sticky_ovf[0])
`endif
  );

  alu_op_issuer #(.W(W), .SHW(SHW), .SETTLE(3), .TAGW(TAGW), .NUM_OPS(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_opcode(cmd_opcode[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_shift(cmd_shift[1]), .cmd_tag(cmd_tag[1]),
    .alu_opcode(alu_opcode[1]), .alu_in1(alu_in1[1]), .alu_in2(alu_in2[1]), .alu_shift(alu_shift[1]),
    .alu_result(alu_result[1]), .alu_carry(alu_carry[1]), .alu_zero(alu_zero[1]),
    .alu_ovf(alu_ovf[1]), .alu_sign(alu_sign[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_flags(rsp_flags[1]), .rsp_tag(rsp_tag[1]), .rsp_err(rsp_err[1]), .op_count(op_count[1])
`ifdef ALU_ISSUE_STICKY_EN
    , .sticky_clr(sticky_clr[1]), .sticky_carry(sticky_carry[1]), .sticky_ovf(sticky_ovf[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input int d, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [SHW-1:0] sh, input logic [TAGW-1:0] tg);
    cmd_valid[d] = 1'b1; cmd_opcode[d] = op; cmd_a[d] = a; cmd_b[d] = b;
    cmd_shift[d] = sh; cmd_tag[d] = tg;
  endtask

  int seen;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_opcode[d] = 4'd0; cmd_a[d] = '0; cmd_b[d] = '0;
      cmd_shift[d] = '0; cmd_tag[d] = '0; rsp_ready[d] = 1'b0;
`ifdef ALU_ISSUE_STICKY_EN
      sticky_clr[d] = 1'b0;
`endif
    end
    repeat (2) tick();

    chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rst_alu_opcode", 32'(alu_opcode[0]), 32'd0);
    chk("rst_alu_in1", 32'(alu_in1[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags[0]), 32'd0);
    chk("rst_op_count", 32'(op_count[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // OR on SETTLE=1 instance
    rsp_ready[0] = 1'b1;
    cmd(0, 4'd7, 16'h00F0, 16'h0F00, 5'd0, 4'd3);
    tick();
    cmd_valid[0] = 1'b0;
    chk("or_alu_opcode", 32'(alu_opcode[0]), 32'd7);
    chk("or_alu_in1", 32'(alu_in1[0]), 32'h00F0);
    chk("or_alu_in2", 32'(alu_in2[0]), 32'h0F00);
    chk("or_cmd_ready_busy", 32'(cmd_ready[0]), 32'd0);
    chk("or_rsp_valid_early", 32'(rsp_valid[0]), 32'd0);
    tick();
    chk("or_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    chk("or_rsp_result", 32'(rsp_result[0]), 32'h0FF0);
    chk("or_rsp_tag", 32'(rsp_tag[0]), 32'd3);
    chk("or_rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("or_rsp_flags", 32'(rsp_flags[0]), 32'd0);
    tick();
    chk("or_op_count", 32'(op_count[0]), 32'd1);
    chk("or_rsp_valid_done", 32'(rsp_valid[0]), 32'd0);
    chk("or_cmd_ready_back", 32'(cmd_ready[0]), 32'd1);
    chk("or_bus_kept", 32'(alu_opcode[0]), 32'd7);

    // SLL on SETTLE=3 instance
    rsp_ready[1] = 1'b1;
    cmd(1, 4'd5, 16'h0001, 16'h0000, 5'd15, 4'd5);
    tick();
    cmd_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sll_shift_c%0d", i), 32'(alu_shift[1]), 32'd15);
      chk($sformatf("sll_rsp_valid_c%0d", i), 32'(rsp_valid[1]), 32'd0);
      tick();
    end
    chk("sll_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    chk("sll_rsp_result", 32'(rsp_result[1]), 32'h8000);
    chk("sll_rsp_flags", 32'(rsp_flags[1]), 32'b0010);
    chk("sll_rsp_tag", 32'(rsp_tag[1]), 32'd5);
    tick();
    chk("sll_op_count", 32'(op_count[1]), 32'd1);

    // Illegal opcode on SETTLE=3 instance
    cmd(1, 4'd12, 16'h1234, 16'h5678, 5'd3, 4'd9);
    tick();
    cmd_valid[1] = 1'b0;
    chk("ill_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    chk("ill_rsp_err", 32'(rsp_err[1]), 32'd1);
    chk("ill_rsp_result", 32'(rsp_result[1]), 32'd0);
    chk("ill_rsp_flags", 32'(rsp_flags[1]), 32'd0);
    chk("ill_rsp_tag", 32'(rsp_tag[1]), 32'd9);
    chk("ill_alu_opcode", 32'(alu_opcode[1]), 32'd5);
    chk("ill_alu_in1", 32'(alu_in1[1]), 32'h0001);
    chk("ill_alu_shift", 32'(alu_shift[1]), 32'd15);
    tick();
    chk("ill_op_count", 32'(op_count[1]), 32'd2);
    chk("ill_cmd_ready", 32'(cmd_ready[1]), 32'd1);

    // Back-pressure on SETTLE=1 instance: ADD 0xFFFF+1 -> 0, carry and zero
    rsp_ready[0] = 1'b0;
    cmd(0, 4'd0, 16'hFFFF, 16'h0001, 5'd0, 4'd6);
    tick();
    cmd(0, 4'd7, 16'h0001, 16'h0002, 5'd0, 4'd7);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_cmd_ready_c%0d", i), 32'(cmd_ready[0]), 32'd0);
      chk($sformatf("bp_rsp_valid_c%0d", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("bp_rsp_tag_c%0d", i), 32'(rsp_tag[0]), 32'd6);
      chk($sformatf("bp_rsp_result_c%0d", i), 32'(rsp_result[0]), 32'd0);
      chk($sformatf("bp_rsp_flags_c%0d", i), 32'(rsp_flags[0]), 32'b1001);
      chk($sformatf("bp_alu_opcode_c%0d", i), 32'(alu_opcode[0]), 32'd0);
      tick();
    end
    rsp_ready[0] = 1'b1;
    tick();
    chk("bp_hs_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp_hs_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("bp_hs_op_count", 32'(op_count[0]), 32'd2);
    tick();
    cmd_valid[0] = 1'b0;
    chk("bp_second_opcode", 32'(alu_opcode[0]), 32'd7);
    chk("bp_second_busy", 32'(cmd_ready[0]), 32'd0);
    tick();
    chk("bp_second_result", 32'(rsp_result[0]), 32'd3);
    chk("bp_second_tag", 32'(rsp_tag[0]), 32'd7);
    tick();
    chk("bp_second_count", 32'(op_count[0]), 32'd3);

    // Asynchronous reset in the middle of DRIVE on SETTLE=3 instance
    cmd(1, 4'd7, 16'h00AA, 16'h5500, 5'd0, 4'hA);
    tick();
    cmd_valid[1] = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_alu_opcode", 32'(alu_opcode[1]), 32'd0);
    chk("ar_alu_in1", 32'(alu_in1[1]), 32'd0);
    chk("ar_cmd_ready", 32'(cmd_ready[1]), 32'd1);
    chk("ar_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("ar_op_count", 32'(op_count[1]), 32'd0);
    chk("ar_op_count_d1", 32'(op_count[0]), 32'd0);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid[1] !== 1'b0) seen++;
    end
    chk("ar_no_response", 32'(seen), 32'd0);

`ifdef ALU_ISSUE_STICKY_EN
    rsp_ready[0] = 1'b1;
    cmd(0, 4'd0, 16'hFFFF, 16'h0001, 5'd0, 4'd1);
    tick(); cmd_valid[0] = 1'b0; tick(); tick();
    chk("st_carry_set", 32'(sticky_carry[0]), 32'd1);
    cmd(0, 4'd7, 16'h0001, 16'h0002, 5'd0, 4'd2);
    tick(); cmd_valid[0] = 1'b0; tick(); tick();
    chk("st_carry_held", 32'(sticky_carry[0]), 32'd1);
    sticky_clr[0] = 1'b1;
    tick();
    sticky_clr[0] = 1'b0;
    chk("st_carry_clr", 32'(sticky_carry[0]), 32'd0);
    cmd(0, 4'd0, 16'h8000, 16'h8000, 5'd0, 4'd3);
    tick(); cmd_valid[0] = 1'b0;
    sticky_clr[0] = 1'b1;
    tick();
    sticky_clr[0] = 1'b0;
    chk("st_carry_wins", 32'(sticky_carry[0]), 32'd1);
    chk("st_ovf_wins", 32'(sticky_ovf[0]), 32'd1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
